ah_rr_arbiter_lock: RTL and testbench
=====================================

Name: ah_rr_arbiter_lock

Overview:
- Parametrised round-robin arbiter with grant locking. Next-generation replacement for the fixed 8-way registered arbiter.
- Arbitrates NUM_REQ requesters with rotating priority. Holds the winner's grant across a multi-cycle transaction until the owner signals done or drops its request.
- Outputs a registered one-hot grant plus an encoded index.
- Sits in front of shared resources such as bus ports and memory banks.

Parameters:
NUM_REQ, 8, number of requesters; legal range 2..32
IDX_W, $clog2(NUM_REQ), width of grant_idx; derived, not overridden
MAX_HOLD, 16, cycles an owner may hold the grant before forced release; used only with AH_RR_HOLD_TIMEOUT_EN; legal range 1..255

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-high
req  input  NUM_REQ  request vector; bit i is requester i
done  input  1  single-cycle pulse from the current owner: transaction complete, release the grant
grant  output  NUM_REQ  registered one-hot grant; all zeros when idle
grant_valid  output  1  registered; equals OR of grant
grant_idx  output  IDX_W  registered binary index of the granted bit; 0 when idle
timeout  output  1  registered one-cycle pulse on forced release; present only with AH_RR_HOLD_TIMEOUT_EN

Behaviour:
- Reset (rst high, asynchronous):
  - grant=0, grant_valid=0, grant_idx=0, timeout=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - State=IDLE, hold counter=0.
  - Reset mid-transaction drops the grant immediately, with no wait for done.
- States: IDLE and OWNED.
- Arbitration (combinational):
  - Search starts at ptr and proceeds ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - The first requester with req high wins.
  - Must be implemented generically, e.g. double-width mask or a thermometer-masked priority encoder. No per-N case tables.
- IDLE:
  - If any req is set: at the next edge grant=onehot(winner), grant_idx=winner, grant_valid=1, go to OWNED.
  - So latency from req rising to grant is 1 cycle.
  - If no req is set: stay in IDLE, outputs zero.
- OWNED (owner = grant_idx):
  - Release condition: done=1, or req[owner]=0. Sampled in the same cycle.
  - No release: grant is held unchanged. Requests from other requesters are ignored.
  - On release: ptr <= owner+1, wrapping NUM_REQ-1 to 0.
  - Same edge: if any req other than the owner is set, grant the winner computed with the new ptr (back-to-back, zero bubble) and stay in OWNED.
  - The releasing owner's bit is masked out of that same-edge arbitration.
  - If no other req is set: grant=0 and go to IDLE. The old owner may be regranted from IDLE on the next cycle (one-cycle bubble).
- done while IDLE: ignored.
- done and req[owner]=0 in the same cycle: treated as a single release.
- grant is never multi-hot. grant_idx always matches grant while grant_valid=1.
- ptr changes only on release, never on a grant that is still held.

Optional Feature:
- Macro: AH_RR_HOLD_TIMEOUT_EN.
- Defined:
  - Add an 8-bit hold counter, cleared on every new grant and incremented each cycle in OWNED.
  - When the counter reaches MAX_HOLD-1 and no release is present, the next edge performs a forced release: identical to done, including ptr advance and back-to-back regrant.
  - The same edge pulses timeout=1 for one cycle.
  - The owner is thus held at most MAX_HOLD cycles.
- Not defined:
  - No counter and no timeout port.
  - Grant is held indefinitely until done or req drop.

Test Plan:
1. NUM_REQ=4. After reset, req=4'b1010. Expected: 1 cycle later grant=0010, idx=1. Pulse done. Expected: next edge grant=1000, idx=3, no bubble.
2. NUM_REQ=4. Hold req=4'b1111 and pulse done every 3 cycles. Expected: grant sequence 0001, 0010, 0100, 1000, 0001 (wrap), each held 3 cycles.
3. NUM_REQ=4. req=0100 only; done pulse. Expected: grant=0 for one cycle (IDLE), then grant=0100 again.
4. NUM_REQ=4. Owner 2 holds the grant while req[0] and req[3] toggle. Expected: grant stays 0100. Drop req[2] with req=1001. Expected: next grant=1000 (ptr=3).
5. NUM_REQ=4. Assert rst asynchronously mid-hold with grant=0010. Expected: grant=0 and idx=0 immediately, before the next clk edge. After release with req=1111, expected grant=0001.
6. With AH_RR_HOLD_TIMEOUT_EN, MAX_HOLD=4, req=0011, no done. Expected: grant=0001 held 4 cycles, then timeout=1 and grant=0010 on the same edge. Without the macro, expected grant=0001 held for 50 cycles.

Source files
------------

// File: rtl/ah_rr_arbiter_lock.sv
// Round-robin arbiter with grant locking: the winner keeps its grant until done or request drop.
// Optional hold timeout (forced release after MAX_HOLD cycles) enabled by AH_RR_HOLD_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no grant outstanding; arbitrate on any request
// S_OWNED | grant_idx owns the resource until release

module ah_rr_arbiter_lock #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
`ifdef AH_RR_HOLD_TIMEOUT_EN
  output logic               timeout,
`endif
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int CW = IDX_W + 1;

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;

  logic [IDX_W-1:0]     owner_next;
  logic                 owner_release;
  logic                 release_now;
  logic [IDX_W-1:0]     arb_ptr;
  logic [NUM_REQ-1:0]   arb_req;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [CW-1:0]        cand;

`ifdef AH_RR_HOLD_TIMEOUT_EN
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 hold_expire;
`endif

  assign owner_next    = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
  assign owner_release = (state_q == S_OWNED) && (done || !req[grant_idx_q]);

`ifdef AH_RR_HOLD_TIMEOUT_EN
  assign hold_expire = (state_q == S_OWNED) && !owner_release &&
                       (hold_cnt_q == 8'(MAX_HOLD - 1));
  assign release_now = owner_release || hold_expire;
`else
  assign release_now = owner_release;
`endif

  // On release the search restarts just past the owner, and the owner itself is excluded.
  assign arb_ptr = (state_q == S_OWNED) ? owner_next : ptr_q;
  assign arb_req = (state_q == S_OWNED) ? (req & ~grant_q) : req;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, arb_ptr} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!win_found && arb_req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
`ifdef AH_RR_HOLD_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = hold_expire;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d       = S_OWNED;
          grant_d       = NUM_REQ'(1) << win_idx;
          grant_valid_d = 1'b1;
          grant_idx_d   = win_idx;
`ifdef AH_RR_HOLD_TIMEOUT_EN
          hold_cnt_d    = '0;
`endif
        end else begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
        end
      end
      S_OWNED: begin
        if (release_now) begin
          ptr_d = owner_next;
          if (win_found) begin
            grant_d       = NUM_REQ'(1) << win_idx;
            grant_valid_d = 1'b1;
            grant_idx_d   = win_idx;
`ifdef AH_RR_HOLD_TIMEOUT_EN
            hold_cnt_d    = '0;
`endif
          end else begin
            state_d       = S_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_idx_d   = '0;
`ifdef AH_RR_HOLD_TIMEOUT_EN
            hold_cnt_d    = '0;
`endif
          end
        end else begin
`ifdef AH_RR_HOLD_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d       = S_IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
`ifdef AH_RR_HOLD_TIMEOUT_EN
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
`ifdef AH_RR_HOLD_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
`ifdef AH_RR_HOLD_TIMEOUT_EN
  assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_ah_rr_arbiter_lock.sv
// Directed bench for ah_rr_arbiter_lock with NUM_REQ=4; hand-computed grant sequences.
// Follows AH_RR_HOLD_TIMEOUT_EN to select the hold-timeout or hold-forever expectations.

module tb_ah_rr_arbiter_lock;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
`ifdef AH_RR_HOLD_TIMEOUT_EN
  logic         timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ah_rr_arbiter_lock #(.NUM_REQ(N), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
`ifdef AH_RR_HOLD_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks grant, grant_valid and grant_idx against one expected one-hot value.
  task automatic chk_g(input string tag, input logic [N-1:0] exp_g);
    logic [1:0] e_idx;
    e_idx = 2'd0;
    for (int i = 0; i < N; i++) if (exp_g[i]) e_idx = 2'(i);
    chk({tag, ".grant"}, 32'(grant), 32'(exp_g));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(|exp_g));
    chk({tag, ".idx"}, 32'(grant_idx), 32'(e_idx));
  endtask

  logic [N-1:0] seq2 [5];

  initial begin
    seq2[0] = 4'b0001; seq2[1] = 4'b0010; seq2[2] = 4'b0100;
    seq2[3] = 4'b1000; seq2[4] = 4'b0001;

    step(); step();
    chk_g("reset", 4'b0000);
`ifdef AH_RR_HOLD_TIMEOUT_EN
    chk("reset.timeout", 32'(timeout), 32'd0);
`endif
    rst = 1'b0;

    done = 1'b1; step(); done = 1'b0;
    chk_g("done_idle", 4'b0000);

    // 1: first grant latency and back-to-back handover
    req = 4'b1010; step();
    chk_g("t1.first", 4'b0010);
    done = 1'b1; step(); done = 1'b0;
    chk_g("t1.b2b", 4'b1000);
    req = 4'b0000; step();
    chk_g("t1.idle", 4'b0000);

    // 2: full rotation with done every 3 cycles, ptr is 0 here
    req = 4'b1111; step();
    for (int k = 0; k < 5; k++) begin
      chk_g($sformatf("t2.g%0d.c1", k), seq2[k]);
      step();
      chk_g($sformatf("t2.g%0d.c2", k), seq2[k]);
      step();
      chk_g($sformatf("t2.g%0d.c3", k), seq2[k]);
      if (k < 4) begin
        done = 1'b1; step(); done = 1'b0;
      end
    end
    req = 4'b0000; step();
    chk_g("t2.idle", 4'b0000);

    // 3: lone requester gets a one-cycle bubble before regrant (ptr=1)
    req = 4'b0100; step();
    chk_g("t3.grant", 4'b0100);
    done = 1'b1; step(); done = 1'b0;
    chk_g("t3.bubble", 4'b0000);
    step();
    chk_g("t3.regrant", 4'b0100);

    // 4: lock ignores other requesters, then drop hands over from ptr=3
    req = 4'b0101; step(); chk_g("t4.hold_a", 4'b0100);
    req = 4'b1100; step(); chk_g("t4.hold_b", 4'b0100);
    req = 4'b1101; step(); chk_g("t4.hold_c", 4'b0100);
    req = 4'b1001; step(); chk_g("t4.drop", 4'b1000);
    req = 4'b0000; step(); chk_g("t4.idle", 4'b0000);

    // 5: asynchronous reset mid-hold
    req = 4'b0010; step();
    chk_g("t5.grant", 4'b0010);
    #2 rst = 1'b1;
    #1 chk_g("t5.async", 4'b0000);
    req = 4'b1111;
    step();
    rst = 1'b0;
    step();
    chk_g("t5.after", 4'b0001);
    req = 4'b0000; step();
    chk_g("t5.idle", 4'b0000);

    // 6: hold timeout, starting from a fresh ptr=0
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0011; step();
`ifdef AH_RR_HOLD_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      chk_g($sformatf("t6.hold%0d", c), 4'b0001);
      chk($sformatf("t6.to%0d", c), 32'(timeout), 32'd0);
      step();
    end
    chk_g("t6.forced", 4'b0010);
    chk("t6.pulse", 32'(timeout), 32'd1);
    step();
    chk("t6.pulse_end", 32'(timeout), 32'd0);
    chk_g("t6.next", 4'b0010);
`else
    for (int c = 0; c < 50; c++) begin
      chk_g($sformatf("t6.hold%0d", c), 4'b0001);
      step();
    end
`endif
    req = 4'b0000; step();
    chk_g("t6.idle", 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
